// File: rtl/inst_issue_queue.sv
// Circular instruction queue: 0/1/2 {inst,pc} pushes and 0/1/2 retires per cycle, head pair exposed.
// Outputs read combinationally from registered state (pushes visible next cycle); full stalls fetch.
module inst_issue_queue #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 push_valid,
    input  logic [INST_W-1:0]          push_inst1,
    input  logic [PC_W-1:0]            push_pc1,
    input  logic [INST_W-1:0]          push_inst2,
    input  logic [PC_W-1:0]            push_pc2,
    input  logic                       issue,
    input  logic                       issue_dual,
    output logic [INST_W-1:0]          out_inst1,
    output logic [PC_W-1:0]            out_pc1,
    output logic [INST_W-1:0]          out_inst2,
    output logic [PC_W-1:0]            out_pc2,
    output logic                       out_valid1,
    output logic                       out_valid2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       err_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [1:0]       n_pop, n_push;
    logic             push_any, do_push;
    logic             wr0_en, wr1_en;
    logic [INST_W-1:0] wr0_inst;
    logic [PC_W-1:0]   wr0_pc;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Fewer than two free slots counts as full so a dual push can never overwrite.
    assign full       = (count > CNT_W'(DEPTH - 2));
    assign out_valid1 = (count != '0);
    assign out_valid2 = (count > CNT_W'(1));

    assign push_any = (push_valid != 2'b00);
    assign do_push  = push_any && !full && !flush;

    always_comb begin
        n_pop = 2'd0;
        if (issue && !flush && out_valid1) begin
            n_pop = (issue_dual && out_valid2) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        n_push = 2'd0;
        if (do_push) begin
            n_push = (push_valid == 2'b11) ? 2'd2 : 2'd1;
        end
    end

    // A lone slot2 push is compacted into the tail entry.
    assign wr0_en   = do_push;
    assign wr1_en   = do_push && (push_valid == 2'b11);
    assign wr0_inst = push_valid[0] ? push_inst1 : push_inst2;
    assign wr0_pc   = push_valid[0] ? push_pc1   : push_pc2;

    always_ff @(posedge clk) begin
        if (!rst && wr0_en) begin
            inst_mem[tail] <= wr0_inst;
            pc_mem[tail]   <= wr0_pc;
        end
        if (!rst && wr1_en) begin
            inst_mem[tail_p1] <= push_inst2;
            pc_mem[tail_p1]   <= push_pc2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_push);
            count <= count + CNT_W'(n_push) - CNT_W'(n_pop);
            if (push_any && full) begin
                err_overflow <= 1'b1;
            end
        end
    end

    assign out_inst1 = out_valid1 ? inst_mem[head]    : '0;
    assign out_pc1   = out_valid1 ? pc_mem[head]      : '0;
    assign out_inst2 = out_valid2 ? inst_mem[head_p1] : '0;
    assign out_pc2   = out_valid2 ? pc_mem[head_p1]   : '0;

endmodule
